// File: rtl/grid_io_tile_cfg_if.sv
// Core-side bundle of the I/O tile: the ccff config chain, its status flags and the per-pad core pins.
interface grid_io_tile_cfg_if #(
   parameter int NUM_PADS = 8
) ();
   logic                ccff_head;
   logic                ccff_shift_en;
   logic                ccff_tail;
   logic                cfg_done;
   logic                cfg_err;
   logic [0:NUM_PADS-1] pin_outpad;
   logic [0:NUM_PADS-1] pin_oe;
   logic [0:NUM_PADS-1] pin_inpad;

   modport master (
      output ccff_head, ccff_shift_en, pin_outpad, pin_oe,
      input  ccff_tail, cfg_done, cfg_err, pin_inpad
   );

   modport slave (
      input  ccff_head, ccff_shift_en, pin_outpad, pin_oe,
      output ccff_tail, cfg_done, cfg_err, pin_inpad
   );
endinterface

// File: rtl/grid_io_tile_cfg.sv
// GPIO tile with shadowed ccff config: a burst commits one cycle after shift_en drops, only if exactly CFG_LEN bits long.
// Pad paths are combinational, or 2 prog_clk cycles when the pad's synchroniser is enabled; the chain has no backpressure.
module grid_io_tile_cfg #(
   parameter int NUM_PADS = 8
) (
   input  logic                prog_clk,
   input  logic                pReset,
   grid_io_tile_cfg_if.slave   cfg,
   inout  wire [0:NUM_PADS-1]  gfpga_pad_GPIO_PAD
);
   localparam int CFG_LEN = 3 * NUM_PADS;
   localparam int CW      = $clog2(CFG_LEN + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(CFG_LEN);
   localparam logic [CW-1:0] CNT_SAT  = CW'(CFG_LEN + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t              state;
   logic [CFG_LEN-1:0]  shadow;
   logic [CFG_LEN-1:0]  active;
   logic [CW-1:0]       cnt;
   logic                done_q;
   logic                err_q;
   logic [0:NUM_PADS-1] sync1;
   logic [0:NUM_PADS-1] sync2;
   logic [0:NUM_PADS-1] pad_oe;
   logic [0:NUM_PADS-1] inpad;

   always_ff @(posedge prog_clk) begin
      if (!pReset) begin
         state  <= IDLE;
         shadow <= '0;
         active <= '0;
         cnt    <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         sync1  <= '0;
         sync2  <= '0;
      end else begin
         sync1 <= gfpga_pad_GPIO_PAD;
         sync2 <= sync1;
         case (state)
            IDLE: begin
               if (cfg.ccff_shift_en) begin
                  shadow <= {shadow[CFG_LEN-2:0], cfg.ccff_head};
                  cnt    <= CW'(1);
                  done_q <= 1'b0;
                  err_q  <= 1'b0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (cfg.ccff_shift_en) begin
                  shadow <= {shadow[CFG_LEN-2:0], cfg.ccff_head};
                  // Saturate one past full length so any over-shift stays detectable.
                  if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
               end else begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               if (cnt == CNT_FULL) begin
                  active <= shadow;
                  done_q <= 1'b1;
               end else begin
                  err_q <= 1'b1;
               end
               cnt   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      pad_oe = '0;
      for (int k = 0; k < NUM_PADS; k++) begin
         case (active[3*k +: 2])
            2'b10:   pad_oe[k] = 1'b1;
            2'b11:   pad_oe[k] = cfg.pin_oe[k];
            default: pad_oe[k] = 1'b0;
         endcase
      end
   end

   // Gate applied after the synchroniser so a mode change to off/output blanks pin_inpad at once.
   always_comb begin
      inpad = '0;
      for (int k = 0; k < NUM_PADS; k++) begin
         case (active[3*k +: 2])
            2'b01:   inpad[k] = active[3*k+2] ? sync2[k] : gfpga_pad_GPIO_PAD[k];
            2'b11:   inpad[k] = cfg.pin_oe[k] ? 1'b0 :
                                (active[3*k+2] ? sync2[k] : gfpga_pad_GPIO_PAD[k]);
            default: inpad[k] = 1'b0;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
      assign gfpga_pad_GPIO_PAD[k] = pad_oe[k] ? cfg.pin_outpad[k] : 1'bz;
   end

   assign cfg.pin_inpad = inpad;
   assign cfg.ccff_tail = shadow[CFG_LEN-1];
   assign cfg.cfg_done  = done_q;
   assign cfg.cfg_err   = err_q;
endmodule

// File: tb/tb_grid_io_tile_cfg.sv
// Bench for grid_io_tile_cfg: bit-level chain model plus per-pad mode rules drive the expected pad and pin values.
module tb_grid_io_tile_cfg;
   localparam int N = 8;
   localparam int L = 3 * N;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   grid_io_tile_cfg_if #(.NUM_PADS(N)) bus ();
   wire  [0:N-1] pad;
   logic [0:N-1] ext_en;
   logic [0:N-1] ext_val;

   for (genvar k = 0; k < N; k++) begin : g_ext
      assign pad[k] = ext_en[k] ? ext_val[k] : 1'bz;
   end

   grid_io_tile_cfg #(.NUM_PADS(N)) dut (
      .prog_clk           (clk),
      .pReset             (rst_n),
      .cfg                (bus),
      .gfpga_pad_GPIO_PAD (pad)
   );

   int tests = 0;
   int fails = 0;
   logic [L-1:0] shadow_m = '0;
   logic [L-1:0] active_m = '0;
   int cnt_m = 0;
   logic [0:N-1] cur_ev, cur_op, cur_oe;

   function automatic logic [1:0] mode_m(input int k);
      return active_m[3*k +: 2];
   endfunction

   function automatic logic drives_m(input int k, input logic oe);
      return (mode_m(k) == 2'b10) || (mode_m(k) == 2'b11 && oe);
   endfunction

   function automatic logic [0:N-1] exp_pad();
      logic [0:N-1] e;
      for (int k = 0; k < N; k++) e[k] = drives_m(k, cur_oe[k]) ? cur_op[k] : cur_ev[k];
      return e;
   endfunction

   // Expected pin_inpad once pads have been stable for at least two cycles.
   function automatic logic [0:N-1] exp_inpad();
      logic [0:N-1] e;
      for (int k = 0; k < N; k++)
         e[k] = ((mode_m(k) == 2'b01) || (mode_m(k) == 2'b11 && !cur_oe[k])) ? cur_ev[k] : 1'b0;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Outside pads only drive where the tile should not; stray tile drives then fight an opposite value.
   task automatic set_pads(input logic [0:N-1] ev, input logic [0:N-1] op, input logic [0:N-1] oe);
      for (int k = 0; k < N; k++) begin
         ext_en[k]  = !drives_m(k, oe[k]);
         ext_val[k] = ev[k];
         cur_op[k]  = drives_m(k, oe[k]) ? op[k] : ~ev[k];
      end
      cur_ev = ev;
      cur_oe = oe;
      bus.pin_outpad = cur_op;
      bus.pin_oe     = oe;
      #1;
   endtask

   task automatic shift_bit(input logic b);
      bus.ccff_shift_en = 1'b1;
      bus.ccff_head     = b;
      tick();
      shadow_m = {shadow_m[L-2:0], b};
      cnt_m++;
   endtask

   task automatic end_burst();
      bus.ccff_shift_en = 1'b0;
      bus.ccff_head     = 1'b0;
      tick();
      tick();
      if (cnt_m == L) active_m = shadow_m;
      cnt_m = 0;
   endtask

   task automatic send_word(input int n, input logic [31:0] w);
      for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
      end_burst();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_pads(N'($urandom), N'($urandom), N'($urandom));
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         tests++; if (bus.ccff_tail !== 1'b0) begin fails++; $display("FAIL reset_tail: got %b want 0", bus.ccff_tail); end
         tests++; if (bus.cfg_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.cfg_done); end
         tests++; if (bus.cfg_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.cfg_err); end
         tests++; if (bus.pin_inpad !== '0) begin fails++; $display("FAIL reset_inpad: got %b want 0", bus.pin_inpad); end
         tests++; if (pad !== exp_pad()) begin fails++; $display("FAIL reset_pad_z: got %b want %b", pad, exp_pad()); end
      end
   endtask

   task automatic test_all_input();
      logic [31:0] w = 32'h0024_9249;
      logic [0:N-1] ev;
      for (int i = L - 1; i >= 0; i--) shift_bit(w[i]);
      bus.ccff_shift_en = 1'b0;
      tick();
      tests++; if (bus.cfg_done !== 1'b0) begin fails++; $display("FAIL in_done_early: got %b want 0", bus.cfg_done); end
      tick();
      active_m = shadow_m;
      cnt_m = 0;
      tests++; if (bus.cfg_done !== 1'b1) begin fails++; $display("FAIL in_done: got %b want 1", bus.cfg_done); end
      tests++; if (bus.cfg_err !== 1'b0) begin fails++; $display("FAIL in_err: got %b want 0", bus.cfg_err); end
      for (int r = 0; r < 4; r++) begin
         ev = N'($urandom);
         ev[3] = 1'b1;
         set_pads(ev, N'($urandom), N'($urandom));
         tests++; if (bus.pin_inpad[3] !== 1'b1) begin fails++; $display("FAIL in_pad3: got %b want 1", bus.pin_inpad[3]); end
         tests++; if (bus.pin_inpad !== exp_inpad()) begin fails++; $display("FAIL in_follow: got %b want %b", bus.pin_inpad, exp_inpad()); end
      end
   endtask

   task automatic test_sync();
      logic [0:N-1] ev;
      logic [0:N-1] want;
      send_word(L, 32'h5);
      set_pads('0, N'($urandom), N'($urandom));
      tick(); tick(); tick();
      tests++; if (bus.pin_inpad !== '0) begin fails++; $display("FAIL sync_idle: got %b want 0", bus.pin_inpad); end
      ev = N'($urandom);
      ev[0] = 1'b1;
      set_pads(ev, N'($urandom), N'($urandom));
      want = '0;
      tests++; if (bus.pin_inpad !== want) begin fails++; $display("FAIL sync_c0: got %b want %b", bus.pin_inpad, want); end
      tick();
      tests++; if (bus.pin_inpad !== want) begin fails++; $display("FAIL sync_c1: got %b want %b", bus.pin_inpad, want); end
      tick();
      want[0] = 1'b1;
      tests++; if (bus.pin_inpad !== want) begin fails++; $display("FAIL sync_c2: got %b want %b", bus.pin_inpad, want); end
   endtask

   task automatic test_bad_length();
      logic first;
      logic [0:N-1] ev;
      send_word(L, 32'h0024_9249);
      send_word(L - 1, $urandom);
      tests++; if (bus.cfg_err !== 1'b1) begin fails++; $display("FAIL short_err: got %b want 1", bus.cfg_err); end
      tests++; if (bus.cfg_done !== 1'b0) begin fails++; $display("FAIL short_done: got %b want 0", bus.cfg_done); end
      ev = N'($urandom);
      set_pads(ev, N'($urandom), N'($urandom));
      tests++; if (bus.pin_inpad !== exp_inpad()) begin fails++; $display("FAIL short_keep: got %b want %b", bus.pin_inpad, exp_inpad()); end
      first = 1'b1;
      shift_bit(first);
      for (int i = 1; i <= L; i++) begin
         shift_bit(1'($urandom));
         tests++; if (bus.ccff_tail !== shadow_m[L-1]) begin fails++; $display("FAIL long_tail%0d: got %b want %b", i, bus.ccff_tail, shadow_m[L-1]); end
         if (i == L - 1) begin
            tests++; if (bus.ccff_tail !== first) begin fails++; $display("FAIL long_tail_first: got %b want %b", bus.ccff_tail, first); end
         end
      end
      end_burst();
      tests++; if (bus.cfg_err !== 1'b1) begin fails++; $display("FAIL long_err: got %b want 1", bus.cfg_err); end
      tests++; if (bus.cfg_done !== 1'b0) begin fails++; $display("FAIL long_done: got %b want 0", bus.cfg_done); end
      ev = N'($urandom);
      set_pads(ev, N'($urandom), N'($urandom));
      tests++; if (bus.pin_inpad !== exp_inpad()) begin fails++; $display("FAIL long_keep: got %b want %b", bus.pin_inpad, exp_inpad()); end
   endtask

   task automatic test_bidir();
      logic [0:N-1] ev, op, oe;
      send_word(L, 32'h0001_8000);
      ev = N'($urandom); op = N'($urandom); oe = N'($urandom);
      op[5] = 1'b1; oe[5] = 1'b1; ev[5] = 1'b0;
      set_pads(ev, op, oe);
      tests++; if (pad[5] !== 1'b1) begin fails++; $display("FAIL bidir_drive: got %b want 1", pad[5]); end
      tests++; if (bus.pin_inpad[5] !== 1'b0) begin fails++; $display("FAIL bidir_drive_in: got %b want 0", bus.pin_inpad[5]); end
      for (int v = 0; v < 2; v++) begin
         oe[5] = 1'b0;
         ev[5] = 1'(v);
         set_pads(ev, op, oe);
         tests++; if (pad[5] !== 1'(v)) begin fails++; $display("FAIL bidir_z%0d: got %b want %0d", v, pad[5], v); end
         tests++; if (bus.pin_inpad[5] !== 1'(v)) begin fails++; $display("FAIL bidir_in%0d: got %b want %0d", v, bus.pin_inpad[5], v); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w = $urandom;
      for (int i = L - 1; i >= L - 12; i--) shift_bit(w[i]);
      rst_n = 1'b0;
      bus.ccff_shift_en = 1'b0;
      tick();
      rst_n = 1'b1;
      shadow_m = '0; active_m = '0; cnt_m = 0;
      set_pads(N'($urandom), N'($urandom), N'($urandom));
      tests++; if (bus.ccff_tail !== 1'b0) begin fails++; $display("FAIL mid_tail: got %b want 0", bus.ccff_tail); end
      tests++; if (bus.cfg_done !== 1'b0) begin fails++; $display("FAIL mid_done: got %b want 0", bus.cfg_done); end
      tests++; if (bus.cfg_err !== 1'b0) begin fails++; $display("FAIL mid_err: got %b want 0", bus.cfg_err); end
      tests++; if (bus.pin_inpad !== '0) begin fails++; $display("FAIL mid_inpad: got %b want 0", bus.pin_inpad); end
      send_word(L, $urandom);
      tests++; if (bus.cfg_done !== 1'b1) begin fails++; $display("FAIL mid_redo_done: got %b want 1", bus.cfg_done); end
      tests++; if (bus.cfg_err !== 1'b0) begin fails++; $display("FAIL mid_redo_err: got %b want 0", bus.cfg_err); end
   endtask

   task automatic test_random();
      int n;
      for (int it = 0; it < 12; it++) begin
         n = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? L + 1 : L - 1) : L;
         send_word(n, $urandom);
         tests++; if (bus.cfg_done !== (n == L)) begin fails++; $display("FAIL rnd_done%0d: got %b want %b", it, bus.cfg_done, n == L); end
         tests++; if (bus.cfg_err !== (n != L)) begin fails++; $display("FAIL rnd_err%0d: got %b want %b", it, bus.cfg_err, n != L); end
         for (int p = 0; p < 3; p++) begin
            set_pads(N'($urandom), N'($urandom), N'($urandom));
            tick();
            tick();
            tests++; if (pad !== exp_pad()) begin fails++; $display("FAIL rnd_pad%0d: got %b want %b", it, pad, exp_pad()); end
            tests++; if (bus.pin_inpad !== exp_inpad()) begin fails++; $display("FAIL rnd_inpad%0d: got %b want %b", it, bus.pin_inpad, exp_inpad()); end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      bus.ccff_head = 1'b0;
      bus.ccff_shift_en = 1'b0;
      bus.pin_outpad = '0;
      bus.pin_oe = '0;
      ext_en = '0;
      ext_val = '0;
      cur_ev = '0; cur_op = '0; cur_oe = '0;
      test_reset();
      test_all_input();
      test_sync();
      test_bad_length();
      test_bidir();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
